// File: rtl/param_seq_detector.sv
// param_seq_detector: Mealy serial pattern detector, LEN-bit pattern that can
// be reloaded at runtime, valid qualifier, overlap mode and a registered match.
// Ports: i_Clk, Reset (sync, active high), Sequence/i_Valid serial input,
//        i_Overlap, i_Load/i_Pattern reload, X (Mealy match),
//        o_Match_Reg (X delayed by one cycle), o_Pattern (active pattern).
// Optional SEQ_DET_MATCH_COUNT_EN: adds i_Count_Clr and o_Match_Count,
//        a saturating match counter.
module param_seq_detector #(
   parameter int             LEN             = 5,
   parameter logic [LEN-1:0] DEFAULT_PATTERN = LEN'(5'b01110),
   parameter int             CNT_W           = 8
) (
   input  logic             i_Clk,
   input  logic             Reset,
   input  logic             Sequence,
   input  logic             i_Valid,
   input  logic             i_Overlap,
   input  logic             i_Load,
   input  logic [LEN-1:0]   i_Pattern,
   output logic             X,
   output logic             o_Match_Reg,
`ifdef SEQ_DET_MATCH_COUNT_EN
   output logic [LEN-1:0]   o_Pattern,
   input  logic             i_Count_Clr,
   output logic [CNT_W-1:0] o_Match_Count
`else
   output logic [LEN-1:0]   o_Pattern
`endif
);

   localparam int FW = $clog2(LEN);
   localparam logic [FW-1:0] FULL = FW'(LEN - 1);

   if (LEN < 2 || LEN > 16 || CNT_W < 1) begin : g_bad_param
      $error("param_seq_detector: LEN must be 2..16 and CNT_W >= 1");
   end

   logic [LEN-1:0] pat_q, pat_d;
   logic [LEN-2:0] hist_q, hist_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic           mreg_q, mreg_d;
   logic [LEN-1:0] win;

   // Window of the last LEN bits including the one arriving now
   assign win = {hist_q, Sequence};

   assign X = i_Valid & ~i_Load & ~Reset
            & (fill_q == FULL) & (win == pat_q);

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      mreg_d = X;
      if (Reset) begin
         pat_d  = DEFAULT_PATTERN;
         hist_d = '0;
         fill_d = '0;
         mreg_d = 1'b0;
      end else if (i_Load) begin
         pat_d  = i_Pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (i_Valid) begin
         hist_d = win[LEN-2:0];
         if (X && !i_Overlap) begin
            fill_d = '0;
         end else if (fill_q != FULL) begin
            fill_d = fill_q + FW'(1);
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      mreg_q <= mreg_d;
   end

   assign o_Match_Reg = mreg_q;
   assign o_Pattern   = pat_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear beats increment; saturate rather than wrap
   always_comb begin
      cnt_d = cnt_q;
      if (Reset || i_Load || i_Count_Clr) begin
         cnt_d = '0;
      end else if (X && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_Clk) begin
      cnt_q <= cnt_d;
   end

   assign o_Match_Count = cnt_q;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed self-checking bench for param_seq_detector
// (LEN=5, CNT_W=2); counter checks build when SEQ_DET_MATCH_COUNT_EN is set.
module tb_param_seq_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       seq = 1'b0;
   logic       vld = 1'b0;
   logic       ov  = 1'b1;
   logic       ld  = 1'b0;
   logic [4:0] pat = '0;
   logic       clr = 1'b0;
   logic       x;
   logic       mreg;
   logic [4:0] opat;
   logic [1:0] cnt;
   logic       prev_x = 1'b0;
   int         n_asrt = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   param_seq_detector #(
      .LEN(5),
      .DEFAULT_PATTERN(5'b01110),
      .CNT_W(2)
   ) dut (
      .i_Clk(clk),
      .Reset(rst),
      .Sequence(seq),
      .i_Valid(vld),
      .i_Overlap(ov),
      .i_Load(ld),
      .i_Pattern(pat),
      .X(x),
      .o_Match_Reg(mreg),
`ifdef SEQ_DET_MATCH_COUNT_EN
      .o_Pattern(opat),
      .i_Count_Clr(clr),
      .o_Match_Count(cnt)
`else
      .o_Pattern(opat)
`endif
   );

`ifndef SEQ_DET_MATCH_COUNT_EN
   assign cnt = '0;
`endif

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive after the rising edge, check on the falling edge.
   // o_Match_Reg must equal the expected X of the previous cycle.
   task automatic step(input logic r, input logic l, input logic v,
                       input logic s, input logic [4:0] p,
                       input logic ex, input string tag);
      @(posedge clk);
      #1;
      rst = r;
      ld  = l;
      vld = v;
      seq = s;
      pat = p;
      @(negedge clk);
      check({tag, " X"}, {15'b0, x}, {15'b0, ex});
      check({tag, " Match_Reg"}, {15'b0, mreg}, {15'b0, prev_x});
      prev_x = ex;
   endtask

   // Sends n valid bits, b[n-1] first; xs[i] is the expected X for bit b[i]
   task automatic stream(input int n, input logic [15:0] b,
                         input logic [15:0] xs, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b1, b[i], 5'b0, xs[i], tag);
      end
   endtask

   initial begin
      // Reset, valid high during reset must not match
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'b0, 1'b0, "rst0");
      step(1'b1, 1'b0, 1'b1, 1'b1, 5'b0, 1'b0, "rst1");
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "idle0");
      check("rst pattern", {11'b0, opat}, 16'h000e);

      // Default pattern 01110
      stream(5, 16'h000e, 16'h0001, "dflt");
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "dflt idle");

      // Overlap on: 0101010 matches at bits 5 and 7
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, "ld 01010");
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "ld idle");
      check("pat 01010", {11'b0, opat}, 16'h000a);
      ov = 1'b1;
      stream(7, 16'h002a, 16'h0005, "ovl1");

      // Overlap off: 01010101010 matches at bits 5 and 11 only
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, "reload");
      ov = 1'b0;
      stream(11, 16'h02aa, 16'h0041, "ovl0");
      ov = 1'b1;

      // Valid gaps with toggling Sequence are transparent
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'b01110, 1'b0, "ld 01110");
      for (int k = 4; k >= 0; k--) begin
         logic [4:0] b;
         b = 5'b01110;
         step(1'b0, 1'b0, 1'b1, b[k], 5'b0, (k == 0), "gap bit");
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b0, g[0], 5'b0, 1'b0, "gap idle");
         end
      end

      // Load mid-stream with a valid bit in the load cycle
      stream(3, 16'h0003, 16'h0000, "pre ld");
      step(1'b0, 1'b1, 1'b1, 1'b1, 5'b11101, 1'b0, "ld+vld");
      check("pat before upd", {11'b0, opat}, 16'h000e);
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "post ld");
      check("pat 11101", {11'b0, opat}, 16'h001d);
      stream(5, 16'h001d, 16'h0001, "new pat");

      // Load collides with the bit that would complete the pattern
      stream(4, 16'h000e, 16'h0000, "pre coll");
      step(1'b0, 1'b1, 1'b1, 1'b1, 5'b11101, 1'b0, "coll");
      step(1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 1'b0, "post coll");

      // Reset mid-operation
      stream(4, 16'h0007, 16'h0000, "pre rst");
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "mid rst");
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b0, "post rst");
      check("rst pat", {11'b0, opat}, 16'h000e);
      stream(5, 16'h000e, 16'h0001, "after rst");
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "after idle");

`ifdef SEQ_DET_MATCH_COUNT_EN
      // Saturating 2-bit counter, pattern 01010, overlap on
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, "cnt ld");
      stream(4, 16'h0005, 16'h0000, "cnt pre");
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b1, "cnt hit");
         step(1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 1'b0, "cnt gap");
         check("cnt sat", {14'b0, cnt}, (k > 3) ? 16'd3 : 16'(k));
      end
      clr = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b1, "clr hit");
      clr = 1'b0;
      step(1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 1'b0, "clr gap");
      check("cnt clr", {14'b0, cnt}, 16'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b1, "cnt hit2");
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "cnt idle");
      check("cnt one", {14'b0, cnt}, 16'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, "cnt ld2");
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, "cnt ld idle");
      check("cnt load", {14'b0, cnt}, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
